rr_arbiter_16: RTL and testbench

Round-robin arbiter that shares one 16-way resource among 16 requesters and drives its select lines. It registers an encoded 4-bit grant index and expands it to a one-hot 16-bit grant through the team's existing `decoder_4x16`. It enforces a bounded hold time per grant and a one-cycle dead gap between grants, so two grants are never active in the same cycle.

---
 rtl/rr_arbiter_16_pkg.sv | 13 +
 rtl/decoder_4x16.sv | 12 +
 rtl/rr_arbiter_16.sv | 112 +++++++++++
 tb/tb_rr_arbiter_16.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: sizes and FSM state encoding.
package rr_arbiter_16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/decoder_4x16.sv
// 4-to-16 one-hot decoder used to drive requester select lines.
module decoder_4x16 (
    input  logic [3:0]  din,
    output logic [15:0] dout
);

    always_comb begin
        dout = 16'h0000;
        dout[din] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with bounded hold time and a one-cycle dead gap
// between grants; the one-hot grant comes only from registered index/valid.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | no grant active, arbitrate when enabled
// ST_GRANT | one grant active, hold_cnt counts its cycles
// ST_GAP   | one dead cycle after a grant, then arbitrate
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic [7:0]       hold_cnt, hold_nxt;
    logic [IDX_W-1:0] winner;
    logic             arbitrate;
    logic [N_REQ-1:0] dec_out;

    // Rotate so that ptr+1 lands at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0]   start;
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        start = p + 1'b1;
        dbl   = {r, r};
        rot   = dbl[start +: N_REQ];
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        return start + off;
    endfunction

    assign winner    = rr_pick(req, ptr);
    assign arbitrate = en && (req != '0);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        hold_nxt  = hold_cnt;
        unique case (state)
            ST_IDLE, ST_GAP: begin
                if (arbitrate) begin
                    state_nxt = ST_GRANT;
                    idx_nxt   = winner;
                    ptr_nxt   = winner;
                    valid_nxt = 1'b1;
                    hold_nxt  = 8'd0;
                end else begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (en && req[gnt_idx] && (hold_cnt < HOLD_LAST)) begin
                    hold_nxt = hold_cnt + 8'd1;
                end else begin
                    state_nxt = ST_GAP;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // ptr resets to 15 so the very first search begins at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '1;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

    decoder_4x16 u_dec (
        .din  (gnt_idx),
        .dout (dec_out)
    );

    assign gnt = dec_out & {N_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: three instances (MAX_HOLD 8/4/3) share stimulus,
// each test checks the instance whose hold limit it exercises.
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;

    logic [15:0] gnt8, gnt4, gnt3;
    logic [3:0]  idx8, idx4, idx3;
    logic        val8, val4, val3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter_16 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8)
    );
    rr_arbiter_16 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4)
    );
    rr_arbiter_16 #(.MAX_HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt3), .gnt_idx(idx3), .gnt_valid(val3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 16'h0000;
        en    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] oh;
        logic [15:0] hold_seq [11];
        int          rot_seq  [5];

        rst_n = 1'b0;
        en    = 1'b1;
        req   = 16'h0000;

        // reset values
        @(negedge clk);
        chk("rst_gnt", gnt8, 16'h0000);
        chk("rst_idx", idx8, 4'h0);
        chk("rst_valid", val8, 1'b0);
        rst_n = 1'b1;

        // first grant after reset goes to index 0, then async reset mid-grant
        req = 16'hFFFF;
        @(negedge clk);
        chk("first_gnt", gnt8, 16'h0001);
        chk("first_idx", idx8, 4'h0);
        @(negedge clk);
        chk("first_hold", gnt8, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt8, 16'h0000);
        chk("async_rst_valid", val8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", gnt8, 16'h0001);
        chk("post_rst_idx", idx8, 4'h0);

        // rotation 0,5,10,15,0 with each requester dropping after two cycles
        do_reset();
        rot_seq = '{0, 5, 10, 15, 0};
        req = 16'h8421;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            oh = 16'h0001 << rot_seq[k];
            chk($sformatf("rot%0d_c1", k), gnt8, oh);
            chk($sformatf("rot%0d_idx", k), idx8, rot_seq[k]);
            @(negedge clk);
            chk($sformatf("rot%0d_c2", k), gnt8, oh);
            req = 16'h8421 & ~oh;
            @(negedge clk);
            chk($sformatf("rot%0d_gap", k), gnt8, 16'h0000);
            req = 16'h8421;
            @(negedge clk);
        end

        // hold expiry with MAX_HOLD=4 and two continuous requesters
        do_reset();
        hold_seq = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000,
                     16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0000, 16'h0001};
        req = 16'h0003;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d", k), gnt4, hold_seq[k]);
        end

        // single requester with MAX_HOLD=3: 3 on, 1 off, repeating
        do_reset();
        req = 16'h0040;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("single_c%0d", k), gnt3, (k % 4 == 3) ? 16'h0000 : 16'h0040);
        end

        // en drop during grant to 15, then wrap to 0 and on to 4
        do_reset();
        req = 16'h8000;
        @(negedge clk);
        chk("en_gnt15", gnt8, 16'h8000);
        chk("en_idx15", idx8, 4'hF);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_gnt", gnt8, 16'h0000);
        chk("en_drop_idx", idx8, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("en_low_c%0d", k), val8, 1'b0);
        end
        en  = 1'b1;
        req = 16'h0011;
        @(negedge clk);
        chk("wrap_gnt0", gnt8, 16'h0001);
        req = 16'h0010;
        @(negedge clk);
        chk("wrap_gap", gnt8, 16'h0000);
        @(negedge clk);
        chk("wrap_gnt4", gnt8, 16'h0010);
        chk("wrap_idx4", idx8, 4'h4);

        // idle with no requests, one-cycle pulse, same-edge handoff 2 -> 7
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("idle_c%0d", k), val8, 1'b0);
        end
        req = 16'h0008;
        @(negedge clk);
        chk("pulse_gnt3", gnt8, 16'h0008);
        req = 16'h0000;
        @(negedge clk);
        chk("pulse_end", gnt8, 16'h0000);
        req = 16'h0004;
        @(negedge clk);
        chk("swap_gnt2", gnt8, 16'h0004);
        req = 16'h0080;
        @(negedge clk);
        chk("swap_gap", gnt8, 16'h0000);
        @(negedge clk);
        chk("swap_gnt7", gnt8, 16'h0080);
        chk("swap_idx7", idx8, 4'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
